pulse_noise_source: RTL

- Excitation source directly downstream of the allophone controller in the Speech256 chain.
- Consumes the controller's period_out and amp_out. Produces one signed excitation sample per sample strobe for the lattice filter.
- Voiced frames (period_in != 0) produce a glottal pulse train. Unvoiced frames (period_in == 0) produce LFSR noise.
- Returns period_done_out to the controller, which uses it to advance through the allophone duration.

---
 rtl/pulse_noise_source.sv | 99 +++++++++
 1 files changed

// File: rtl/pulse_noise_source.sv
// Excitation source: a glottal pulse train for voiced frames and LFSR noise for unvoiced frames.
// Optional macro PULSE_NOISE_SOURCE_MIXED_EN adds low-level noise to the voiced non-pulse samples.
module pulse_noise_source #(
  parameter int          UNVOICED_LEN = 64,
  parameter logic [16:0] LFSR_SEED    = 17'h00001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_stb,
  input  logic [7:0]  period_in,
  input  logic [15:0] amp_in,
  output logic [15:0] source_out,
  output logic        source_stb,
  output logic        period_done_out
);

  // UNVOICED_LEN is at most 256, so len-1 always fits in 8 bits.
  localparam logic [7:0] UV_LEN_M1 = 8'(UNVOICED_LEN - 1);

  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  period_q, period_d;
  logic [15:0] amp_q, amp_d;
  logic [16:0] lfsr_q, lfsr_d;
  logic [15:0] source_d;
  logic        done_d;

  logic        start;
  logic        noise;
  logic [7:0]  period_eff;
  logic [15:0] amp_eff;
  logic [15:0] quarter;
`ifdef PULSE_NOISE_SOURCE_MIXED_EN
  logic [15:0] sixteenth;
`endif

  always_comb begin
    start      = (cnt_q == 8'd0);
    noise      = lfsr_q[16] ^ lfsr_q[13];
    // A period start must use the values being latched in this same cycle.
    period_eff = start ? period_in : period_q;
    amp_eff    = start ? amp_in : amp_q;
    quarter    = {2'b00, amp_eff[15:2]};
`ifdef PULSE_NOISE_SOURCE_MIXED_EN
    sixteenth  = {4'b0000, amp_eff[15:4]};
`endif

    cnt_d      = cnt_q;
    period_d   = period_q;
    amp_d      = amp_q;
    lfsr_d     = lfsr_q;
    source_d   = source_out;
    done_d     = 1'b0;

    if (sample_stb) begin
      lfsr_d = {lfsr_q[15:0], noise};
      if (start) begin
        period_d = period_in;
        amp_d    = amp_in;
        cnt_d    = (period_in != 8'd0) ? (period_in - 8'd1) : UV_LEN_M1;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
      done_d = (cnt_d == 8'd0);

      if (period_eff == 8'd0) begin
        source_d = noise ? quarter : (16'd0 - quarter);
      end else if (start) begin
        source_d = {1'b0, amp_eff[15:1]};
      end else begin
`ifdef PULSE_NOISE_SOURCE_MIXED_EN
        source_d = noise ? sixteenth : (16'd0 - sixteenth);
`else
        source_d = 16'd0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q           <= 8'd0;
      period_q        <= 8'd0;
      amp_q           <= 16'd0;
      lfsr_q          <= LFSR_SEED;
      source_out      <= 16'd0;
      source_stb      <= 1'b0;
      period_done_out <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      period_q        <= period_d;
      amp_q           <= amp_d;
      lfsr_q          <= lfsr_d;
      source_out      <= source_d;
      source_stb      <= sample_stb;
      period_done_out <= done_d;
    end
  end

endmodule
